// File: rtl/instruction_execute.sv
// Execute stage: forwarding muxes, ALU, BEQ resolution with a two-slot squash window,
// and load-use bubble insertion. All outputs except load_use_hazard_x70 are registered.
module instruction_execute (
    input  logic               clk_x70,
    input  logic               rst_x70,
    input  logic               stall_x70,
    input  logic [2:0]         inst_type_x70,
    input  logic signed [31:0] A_x70,
    input  logic signed [31:0] B_x70,
    input  logic [4:0]         sourceA_x70,
    input  logic [4:0]         sourceB_x70,
    input  logic [4:0]         target_x70,
    input  logic signed [25:0] Joffset_x70,
    input  logic [31:0]        pc_x70,
    input  logic [31:0]        wb_fwd_tapout_value_x70,
    input  logic [4:0]         wb_fwd_tapout_target_x70,
    input  logic               wb_fwd_valid_x70,
    output logic [31:0]        alu_result_x70,
    output logic [4:0]         dest_x70,
    output logic               reg_write_en_x70,
    output logic               mem_read_x70,
    output logic               valid_out_x70,
    output logic               branch_taken_x70,
    output logic [31:0]        branch_target_x70,
    output logic               flush_x70,
    output logic               load_use_hazard_x70
);

    typedef enum logic [2:0] {
        OpNop = 3'd0,
        OpAdd = 3'd1,
        OpSub = 3'd2,
        OpAnd = 3'd3,
        OpOr  = 3'd4,
        OpBeq = 3'd5,
        OpLw  = 3'd6,
        OpSlt = 3'd7
    } op_e;

    op_e         op;
    logic [1:0]  squash_q, squash_d;
    logic        squashing;

    logic        ex_fwd_ok;
    logic        ex_fwd_a, ex_fwd_b;
    logic        wb_fwd_ok;
    logic        wb_fwd_a, wb_fwd_b;
    logic [31:0] op_a, op_b;

    logic [31:0] sum, diff, br_off, br_target;
    logic        slt_bit, eq_bit;

    logic [31:0] alu_result_d;
    logic [4:0]  dest_d;
    logic        reg_write_en_d;
    logic        mem_read_d;
    logic        valid_out_d;
    logic        branch_taken_d;
    logic [31:0] branch_target_d;
    logic        flush_d;

    assign op        = op_e'(inst_type_x70);
    assign squashing = (squash_q != 2'd0);

    // A held load cannot forward its address; its data arrives later via the WB tap.
    assign ex_fwd_ok = reg_write_en_x70 && !mem_read_x70 && (dest_x70 != 5'd0);
    assign ex_fwd_a  = ex_fwd_ok && (dest_x70 == sourceA_x70);
    assign ex_fwd_b  = ex_fwd_ok && (dest_x70 == sourceB_x70);

    assign wb_fwd_ok = wb_fwd_valid_x70 && (wb_fwd_tapout_target_x70 != 5'd0);
    assign wb_fwd_a  = wb_fwd_ok && (wb_fwd_tapout_target_x70 == sourceA_x70);
    assign wb_fwd_b  = wb_fwd_ok && (wb_fwd_tapout_target_x70 == sourceB_x70);

    always_comb begin
        op_a = A_x70;
        if (ex_fwd_a) begin
            op_a = alu_result_x70;
        end else if (wb_fwd_a) begin
            op_a = wb_fwd_tapout_value_x70;
        end
    end

    always_comb begin
        op_b = B_x70;
        if (ex_fwd_b) begin
            op_b = alu_result_x70;
        end else if (wb_fwd_b) begin
            op_b = wb_fwd_tapout_value_x70;
        end
    end

    assign sum       = op_a + op_b;
    assign diff      = op_a - op_b;
    assign slt_bit   = ($signed(op_a) < $signed(op_b));
    assign eq_bit    = (op_a == op_b);
    assign br_off    = {{4{Joffset_x70[25]}}, Joffset_x70, 2'b00};
    assign br_target = pc_x70 + 32'd4 + br_off;

    assign load_use_hazard_x70 = valid_out_x70 && mem_read_x70 && (dest_x70 != 5'd0) &&
                                 (op != OpNop) && !squashing &&
                                 ((sourceA_x70 == dest_x70) ||
                                  ((sourceB_x70 != 5'd0) && (sourceB_x70 == dest_x70)));

    always_comb begin
        alu_result_d    = 32'd0;
        dest_d          = 5'd0;
        reg_write_en_d  = 1'b0;
        mem_read_d      = 1'b0;
        valid_out_d     = 1'b0;
        branch_taken_d  = 1'b0;
        branch_target_d = 32'd0;
        flush_d         = 1'b0;
        squash_d        = squash_q;

        if (squashing) begin
            squash_d = squash_q - 2'd1;
        end else if ((op != OpNop) && !load_use_hazard_x70) begin
            valid_out_d = 1'b1;
            case (op)
                OpAdd: begin
                    alu_result_d   = sum;
                    dest_d         = target_x70;
                    reg_write_en_d = 1'b1;
                end
                OpSub: begin
                    alu_result_d   = diff;
                    dest_d         = target_x70;
                    reg_write_en_d = 1'b1;
                end
                OpAnd: begin
                    alu_result_d   = op_a & op_b;
                    dest_d         = target_x70;
                    reg_write_en_d = 1'b1;
                end
                OpOr: begin
                    alu_result_d   = op_a | op_b;
                    dest_d         = target_x70;
                    reg_write_en_d = 1'b1;
                end
                OpSlt: begin
                    alu_result_d   = {31'd0, slt_bit};
                    dest_d         = target_x70;
                    reg_write_en_d = 1'b1;
                end
                OpLw: begin
                    alu_result_d   = sum;
                    dest_d         = target_x70;
                    reg_write_en_d = 1'b1;
                    mem_read_d     = 1'b1;
                end
                OpBeq: begin
                    branch_target_d = br_target;
                    if (eq_bit) begin
                        branch_taken_d = 1'b1;
                        flush_d        = 1'b1;
                        squash_d       = 2'd2;
                    end
                end
                default: begin
                    valid_out_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_x70) begin
        if (rst_x70) begin
            alu_result_x70    <= 32'd0;
            dest_x70          <= 5'd0;
            reg_write_en_x70  <= 1'b0;
            mem_read_x70      <= 1'b0;
            valid_out_x70     <= 1'b0;
            branch_taken_x70  <= 1'b0;
            branch_target_x70 <= 32'd0;
            flush_x70         <= 1'b0;
            squash_q          <= 2'd0;
        end else if (!stall_x70) begin
            alu_result_x70    <= alu_result_d;
            dest_x70          <= dest_d;
            reg_write_en_x70  <= reg_write_en_d;
            mem_read_x70      <= mem_read_d;
            valid_out_x70     <= valid_out_d;
            branch_taken_x70  <= branch_taken_d;
            branch_target_x70 <= branch_target_d;
            flush_x70         <= flush_d;
            squash_q          <= squash_d;
        end
    end

endmodule

// File: tb/tb_instruction_execute.sv
// Directed-vector bench for instruction_execute with hand-computed expected values.
module tb_instruction_execute;

    logic               clk_x70 = 1'b0;
    logic               rst_x70;
    logic               stall_x70;
    logic [2:0]         inst_type_x70;
    logic signed [31:0] A_x70, B_x70;
    logic [4:0]         sourceA_x70, sourceB_x70, target_x70;
    logic signed [25:0] Joffset_x70;
    logic [31:0]        pc_x70;
    logic [31:0]        wb_fwd_tapout_value_x70;
    logic [4:0]         wb_fwd_tapout_target_x70;
    logic               wb_fwd_valid_x70;
    logic [31:0]        alu_result_x70;
    logic [4:0]         dest_x70;
    logic               reg_write_en_x70, mem_read_x70, valid_out_x70;
    logic               branch_taken_x70, flush_x70, load_use_hazard_x70;
    logic [31:0]        branch_target_x70;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, AND = 3'd3, OR = 3'd4,
                           BEQ = 3'd5, LW = 3'd6, SLT = 3'd7;

    instruction_execute dut (
        .clk_x70                  (clk_x70),
        .rst_x70                  (rst_x70),
        .stall_x70                (stall_x70),
        .inst_type_x70            (inst_type_x70),
        .A_x70                    (A_x70),
        .B_x70                    (B_x70),
        .sourceA_x70              (sourceA_x70),
        .sourceB_x70              (sourceB_x70),
        .target_x70               (target_x70),
        .Joffset_x70              (Joffset_x70),
        .pc_x70                   (pc_x70),
        .wb_fwd_tapout_value_x70  (wb_fwd_tapout_value_x70),
        .wb_fwd_tapout_target_x70 (wb_fwd_tapout_target_x70),
        .wb_fwd_valid_x70         (wb_fwd_valid_x70),
        .alu_result_x70           (alu_result_x70),
        .dest_x70                 (dest_x70),
        .reg_write_en_x70         (reg_write_en_x70),
        .mem_read_x70             (mem_read_x70),
        .valid_out_x70            (valid_out_x70),
        .branch_taken_x70         (branch_taken_x70),
        .branch_target_x70        (branch_target_x70),
        .flush_x70                (flush_x70),
        .load_use_hazard_x70      (load_use_hazard_x70)
    );

    always #5 clk_x70 = ~clk_x70;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] tg);
        inst_type_x70 = t;
        A_x70         = a;
        B_x70         = b;
        sourceA_x70   = sa;
        sourceB_x70   = sb;
        target_x70    = tg;
    endtask

    task automatic branch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                          input logic [25:0] j);
        drive(BEQ, a, b, 5'd0, 5'd0, 5'd0);
        pc_x70      = pc;
        Joffset_x70 = j;
    endtask

    task automatic wb(input logic v, input logic [4:0] tg, input logic [31:0] val);
        wb_fwd_valid_x70         = v;
        wb_fwd_tapout_target_x70 = tg;
        wb_fwd_tapout_value_x70  = val;
    endtask

    task automatic step();
        @(posedge clk_x70);
        #1;
    endtask

    initial begin
        rst_x70   = 1'b1;
        stall_x70 = 1'b0;
        drive(NOP, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        pc_x70      = 32'd0;
        Joffset_x70 = 26'd0;
        wb(1'b0, 5'd0, 32'd0);
        step();
        step();
        rst_x70 = 1'b0;
        chk("reset_valid", {31'd0, valid_out_x70}, 32'd0);
        chk("reset_alu", alu_result_x70, 32'd0);
        chk("reset_flush", {31'd0, flush_x70}, 32'd0);
        chk("reset_dest", {27'd0, dest_x70}, 32'd0);

        // ADD R3 = R1 + R2
        drive(ADD, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3);
        #1 chk("add_no_hazard", {31'd0, load_use_hazard_x70}, 32'd0);
        step();
        chk("add_result", alu_result_x70, 32'd12);
        chk("add_dest", {27'd0, dest_x70}, 32'd3);
        chk("add_we", {31'd0, reg_write_en_x70}, 32'd1);
        chk("add_valid", {31'd0, valid_out_x70}, 32'd1);

        // SUB R4 = R3 - R2, EX/MEM beats WB tap for R3
        drive(SUB, 32'd0, 32'd7, 5'd3, 5'd2, 5'd4);
        wb(1'b1, 5'd3, 32'd99);
        step();
        chk("sub_exfwd", alu_result_x70, 32'd5);
        chk("sub_dest", {27'd0, dest_x70}, 32'd4);

        // AND with A from WB tap (R6)
        drive(AND, 32'd0, 32'h0000_00FF, 5'd6, 5'd0, 5'd5);
        wb(1'b1, 5'd6, 32'h0000_F0F0);
        step();
        chk("and_wbfwd", alu_result_x70, 32'h0000_00F0);
        wb(1'b0, 5'd0, 32'd0);

        // OR with B forwarded from EX/MEM (R5 = 0xF0)
        drive(OR, 32'h0000_0100, 32'd0, 5'd0, 5'd5, 5'd7);
        step();
        chk("or_exfwd_b", alu_result_x70, 32'h0000_01F0);

        drive(SLT, 32'hFFFF_FFFD, 32'd2, 5'd0, 5'd0, 5'd8);
        step();
        chk("slt_true", alu_result_x70, 32'd1);
        drive(SLT, 32'd2, 32'hFFFF_FFFD, 5'd0, 5'd0, 5'd8);
        step();
        chk("slt_false", alu_result_x70, 32'd0);
        drive(ADD, 32'hFFFF_FFFF, 32'd2, 5'd0, 5'd0, 5'd9);
        step();
        chk("add_wrap", alu_result_x70, 32'd1);

        // Taken BEQ: pc 0x100, offset -2 -> 0xFC; two squashed ADDs, third runs
        branch(32'd4, 32'd4, 32'h100, 26'h3FF_FFFE);
        step();
        chk("beq_taken", {31'd0, branch_taken_x70}, 32'd1);
        chk("beq_target", branch_target_x70, 32'h0000_00FC);
        chk("beq_flush", {31'd0, flush_x70}, 32'd1);
        chk("beq_we", {31'd0, reg_write_en_x70}, 32'd0);
        drive(ADD, 32'd1, 32'd1, 5'd0, 5'd0, 5'd9);
        step();
        chk("sq1_valid", {31'd0, valid_out_x70}, 32'd0);
        chk("sq1_flush", {31'd0, flush_x70}, 32'd0);
        chk("sq1_alu", alu_result_x70, 32'd0);
        step();
        chk("sq2_valid", {31'd0, valid_out_x70}, 32'd0);
        step();
        chk("post_sq_valid", {31'd0, valid_out_x70}, 32'd1);
        chk("post_sq_alu", alu_result_x70, 32'd2);

        // Not-taken BEQ still computes target; no squash afterwards
        branch(32'd4, 32'd5, 32'h200, 26'd3);
        step();
        chk("beqnt_taken", {31'd0, branch_taken_x70}, 32'd0);
        chk("beqnt_target", branch_target_x70, 32'h0000_0210);
        chk("beqnt_flush", {31'd0, flush_x70}, 32'd0);
        drive(ADD, 32'd2, 32'd3, 5'd0, 5'd0, 5'd9);
        step();
        chk("beqnt_next_valid", {31'd0, valid_out_x70}, 32'd1);

        // Load-use: LW R5 then ADD using R5
        drive(LW, 32'h10, 32'd4, 5'd0, 5'd0, 5'd5);
        step();
        chk("lw_addr", alu_result_x70, 32'h14);
        chk("lw_mr", {31'd0, mem_read_x70}, 32'd1);
        drive(ADD, 32'd0, 32'd1, 5'd5, 5'd0, 5'd6);
        #1 chk("lu_hazard", {31'd0, load_use_hazard_x70}, 32'd1);
        step();
        chk("lu_bubble", {31'd0, valid_out_x70}, 32'd0);
        wb(1'b1, 5'd5, 32'h20);
        #1 chk("lu_clear", {31'd0, load_use_hazard_x70}, 32'd0);
        step();
        chk("lu_readd", alu_result_x70, 32'h21);
        chk("lu_readd_valid", {31'd0, valid_out_x70}, 32'd1);
        wb(1'b0, 5'd0, 32'd0);

        // Stall inside squash window
        branch(32'd7, 32'd7, 32'h40, 26'd1);
        step();
        chk("st_beq_flush", {31'd0, flush_x70}, 32'd1);
        stall_x70 = 1'b1;
        drive(ADD, 32'd10, 32'd20, 5'd0, 5'd0, 5'd11);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_flush_hold", {31'd0, flush_x70}, 32'd1);
            chk("st_target_hold", branch_target_x70, 32'h48);
        end
        stall_x70 = 1'b0;
        step();
        chk("st_sq1", {31'd0, valid_out_x70}, 32'd0);
        chk("st_sq1_flush", {31'd0, flush_x70}, 32'd0);
        step();
        chk("st_sq2", {31'd0, valid_out_x70}, 32'd0);
        step();
        chk("st_exec", alu_result_x70, 32'd30);

        // Reset with stall, squash counter at 2
        branch(32'd1, 32'd1, 32'h80, 26'd0);
        step();
        rst_x70   = 1'b1;
        stall_x70 = 1'b1;
        step();
        chk("rst_valid", {31'd0, valid_out_x70}, 32'd0);
        chk("rst_flush", {31'd0, flush_x70}, 32'd0);
        chk("rst_target", branch_target_x70, 32'd0);
        rst_x70   = 1'b0;
        stall_x70 = 1'b0;
        drive(ADD, 32'd3, 32'd4, 5'd0, 5'd0, 5'd12);
        step();
        chk("rst_next_valid", {31'd0, valid_out_x70}, 32'd1);
        chk("rst_next_alu", alu_result_x70, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
